// File: rtl/seq_bit_serializer.sv
// Serializes parallel words MSB-first onto x for the sequence detector; en paces the stream.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit after each word's LSB.
module seq_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW       = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [FRAME-1:0] shift_reg;
    logic [CW-1:0]    cnt_reg;
    logic             x_reg;
    logic             x_valid_reg;
    logic             busy_reg;

    logic             last_consume;
    logic             handshake;
    logic [FRAME-1:0] load_word;

`ifdef SEQ_SERIALIZER_PARITY_EN
    assign load_word = {din, ^din};
`else
    assign load_word = din;
`endif

    // The last bit is consumed only on an enabled edge, so done and load_ready
    // both follow en in that cycle; this is what lets a reload stream gap-free.
    assign last_consume = (state_reg == SHIFT) && (cnt_reg == LAST_CNT) && en;
    assign load_ready   = (state_reg == IDLE) || last_consume;
    assign handshake    = load_valid && load_ready;
    assign done         = last_consume;

    assign x       = x_reg;
    assign x_valid = x_valid_reg;
    assign busy    = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            x_reg       <= IDLE_BIT;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else if (handshake) begin
            state_reg   <= SHIFT;
            shift_reg   <= load_word;
            cnt_reg     <= '0;
            x_reg       <= din[WIDTH-1];
            x_valid_reg <= 1'b1;
            busy_reg    <= 1'b1;
        end else if (state_reg == SHIFT && en) begin
            if (cnt_reg != LAST_CNT) begin
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg + CW'(1);
                x_reg     <= shift_reg[FRAME-2];
            end else begin
                state_reg   <= IDLE;
                cnt_reg     <= '0;
                x_reg       <= IDLE_BIT;
                x_valid_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomized bench for seq_bit_serializer against a bit-queue reference model.
// Honours SEQ_SERIALIZER_PARITY_EN so the same bench covers both builds.
module tb_seq_bit_serializer;

    localparam int   W        = 8;
    localparam logic IDLE_BIT = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] word_q[$];
    bit           bq[$];
    bit           lq[$];

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_BIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    // Expected frame: word bits MSB first, then optionally the XOR of all bits.
    task automatic push_frame(input logic [W-1:0] w);
        bit par;
        par = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            bq.push_back(w[i]);
            lq.push_back(1'b0);
            par = par ^ w[i];
        end
        if (PARITY) begin
            bq.push_back(par);
            lq.push_back(1'b0);
        end
        lq[lq.size() - 1] = 1'b1;
    endtask

    // Entered and left just after a rising edge. Streams word_q; with b2b the next
    // word is always offered, otherwise a single 8'hFF offer is made at pulse_cyc.
    task automatic stream(input int period, input bit b2b, input int pulse_cyc, input string tag);
        logic [W-1:0] words[$];
        logic [4:0]   obs;
        logic [4:0]   exp;
        int           wi;
        int           cyc;
        int           nbits;
        int           ndone;
        bit           e_last;
        bit           was_last;
        words = word_q;
        word_q.delete();
        bq.delete();
        lq.delete();
        foreach (words[i]) push_frame(words[i]);
        nbits = bq.size();
        ndone = 0;

        din        = words[0];
        load_valid = 1'b1;
        en         = 1'($urandom);
        @(negedge clk);
        n_checks++;
        obs = {x, x_valid, busy, done, load_ready};
        exp = {IDLE_BIT, 4'b0001};
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s_idle {x,x_valid,busy,done,load_ready} got %b want %b", tag, obs, exp);
        end
        @(posedge clk); #1;

        wi  = 1;
        cyc = 0;
        while (bq.size() > 0 && cyc < 2000) begin
            en = (period <= 1) ? 1'b1 : ((cyc % period) == period - 1);
            if (b2b && wi < words.size()) begin
                load_valid = 1'b1;
                din        = words[wi];
            end else begin
                load_valid = (cyc == pulse_cyc);
                din        = load_valid ? '1 : W'($urandom);
            end
            @(negedge clk);
            e_last = lq[0] && en;
            n_checks++;
            obs = {x, x_valid, busy, done, load_ready};
            exp = {bq[0], 1'b1, 1'b1, e_last, e_last};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s_bit%0d {x,x_valid,busy,done,load_ready} got %b want %b",
                         tag, nbits - bq.size(), obs, exp);
            end
            if (e_last) ndone++;
            @(posedge clk); #1;
            if (en) begin
                void'(bq.pop_front());
                was_last = lq.pop_front();
                if (was_last && load_valid && b2b) wi++;
            end
            cyc++;
        end
        if (cyc >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout bits left %0d want 0", tag, bq.size());
        end

        load_valid = 1'b0;
        en         = 1'($urandom);
        @(negedge clk);
        n_checks++;
        obs = {x, x_valid, busy, done, load_ready};
        exp = {IDLE_BIT, 4'b0001};
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s_end {x,x_valid,busy,done,load_ready} got %b want %b", tag, obs, exp);
        end
        $display("stream %s: words=%0d bits=%0d period=%0d done_pulses=%0d", tag, words.size(), nbits, period, ndone);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n      = 1'b0;
        en         = 1'b0;
        din        = '0;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        obs = {x, x_valid, busy, done, load_ready};
        if (obs !== {IDLE_BIT, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_values got %b want %b", obs, {IDLE_BIT, 4'b0001});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom);
            @(negedge clk);
            n_checks++;
            obs = {x, x_valid, busy, done, load_ready};
            if (obs !== {IDLE_BIT, 4'b0001}) begin
                n_fail++;
                $display("FAIL reset_idle%0d got %b want %b", i, obs, {IDLE_BIT, 4'b0001});
            end
            @(posedge clk); #1;
        end
        $display("reset: held 3 cycles then 10 idle cycles");
    endtask

    task automatic test_single();
        word_q.push_back(8'hB4);
        stream(1, 1'b0, -1, "single_b4");
        word_q.push_back(8'hA7);
        stream(1, 1'b0, -1, "single_a7");
    endtask

    task automatic test_back_to_back();
        word_q.push_back(8'hF0);
        word_q.push_back(8'h0F);
        stream(1, 1'b1, -1, "b2b_f0_0f");
    endtask

    task automatic test_enable_pacing();
        word_q.push_back(8'h81);
        stream(3, 1'b0, -1, "pace_81");
    endtask

    task automatic test_busy_rejection();
        word_q.push_back(8'h00);
        stream(1, 1'b0, 3, "busy_reject");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] w;
        logic [4:0] obs;
        w          = 8'hAA;
        din        = w;
        load_valid = 1'b1;
        en         = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({x, x_valid} !== {w[3], 1'b1}) begin
            n_fail++;
            $display("FAIL midframe_bit4 {x,x_valid} got %b want %b", {x, x_valid}, {w[3], 1'b1});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        obs = {x, x_valid, busy, done, load_ready};
        if (obs !== {IDLE_BIT, 4'b0001}) begin
            n_fail++;
            $display("FAIL midframe_async_reset got %b want %b", obs, {IDLE_BIT, 4'b0001});
        end
        @(posedge clk); #1;
        n_checks++;
        obs = {x, x_valid, busy, done, load_ready};
        if (obs !== {IDLE_BIT, 4'b0001}) begin
            n_fail++;
            $display("FAIL midframe_held_reset got %b want %b", obs, {IDLE_BIT, 4'b0001});
        end
        rst_n = 1'b1;
        $display("reset mid-frame: aborted 8'hAA at bit 4");
        word_q.push_back(8'h55);
        stream(1, 1'b0, -1, "after_reset_55");
    endtask

    task automatic test_random();
        int nw;
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) word_q.push_back(W'($urandom));
            stream($urandom_range(1, 3), 1'b1, -1, $sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_pacing();
        test_busy_rejection();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
